// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD host command-line PHY.
// The SDHOST_CMD_NCC_EN macro adds the NCC idle state to the state enum.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_TURN,
        ST_WAIT_START,
        ST_RECV,
        ST_CHECK,
        ST_HOLD
`ifdef SDHOST_CMD_NCC_EN
        , ST_NCC
`endif
    } state_t;

    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_136  = 2'b01;
    localparam logic [1:0] RESP_48   = 2'b10;
    localparam logic [1:0] RESP_48B  = 2'b11;

    localparam int FRAME_LEN_48  = 48;
    localparam int FRAME_LEN_136 = 136;

    // x^7 + x^3 + 1 with the x^7 term implied by the shift
    localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator/checker, one data bit per enable, MSB first.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data,
    output logic [6:0] crc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc <= 7'd0;
        end else if (clear) begin
            crc <= 7'd0;
        end else if (enable) begin
            crc <= {crc[5:0], 1'b0} ^ ({7{data ^ crc[6]}} & CRC7_POLY);
        end
    end

endmodule

// File: rtl/sd_cmd_phy.sv
// SD host CMD-line PHY: sends a 48-bit command, captures and checks the response.
// Define SDHOST_CMD_NCC_EN to enforce NCC_BITS idle bit periods after each command.
module sd_cmd_phy
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_BITS = 64
`ifdef SDHOST_CMD_NCC_EN
    , parameter int NCC_BITS = 8
`endif
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         bit_en,
    input  logic         cmd_start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_argument,
    input  logic [1:0]   resp_type,
    input  logic         crc_check_en,
    input  logic         index_check_en,
    input  logic         timeout_enable,
    input  logic         cmd_pin_in,
    output logic         cmd_pin_out,
    output logic         cmd_oe,
    output logic         busy,
    output logic         done,
    output logic [127:0] response,
    output logic         resp_valid,
    input  logic         resp_ack,
    output logic         crc_err,
    output logic         end_bit_err,
    output logic         index_err,
    output logic         timeout_err
);

    localparam int TW = $clog2(TIMEOUT_BITS + 1);

    state_t         state;
    logic [39:0]    tx_shift;
    logic [127:0]   rx_shift;
    logic [7:0]     bit_cnt;
    logic [TW-1:0]  wait_cnt;
    logic [5:0]     index_q;
    logic           crc_chk_q, idx_chk_q, tmo_en_q, resp_none_q, resp_long_q;
    logic [6:0]     crc_tx, crc_rx;
    logic           crc_clear, tx_crc_en, rx_crc_en, rx_start, rx_in_range;
    logic [7:0]     rx_pos, last_bit;

    // The RX CRC covers R[47:8] of a short reply and R[127:8] of a long one,
    // so the start bit feeds it only for short replies.
    always_comb begin
        crc_clear   = (state == ST_IDLE) && cmd_start;
        tx_crc_en   = (state == ST_SEND) && bit_en && (bit_cnt < 8'd40);
        rx_start    = (state == ST_WAIT_START) && bit_en && !cmd_pin_in;
        rx_pos      = (state == ST_RECV) ? bit_cnt : 8'd0;
        rx_in_range = resp_long_q ? ((rx_pos >= 8'd8) && (rx_pos < 8'd128)) : (rx_pos < 8'd40);
        rx_crc_en   = (rx_start || ((state == ST_RECV) && bit_en)) && rx_in_range;
        last_bit    = resp_long_q ? 8'(FRAME_LEN_136 - 1) : 8'(FRAME_LEN_48 - 1);
    end

    sd_crc7 u_crc_tx (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (tx_crc_en),
        .data   (tx_shift[39]),
        .crc    (crc_tx)
    );

    sd_crc7 u_crc_rx (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (rx_crc_en),
        .data   (cmd_pin_in),
        .crc    (crc_rx)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cmd_pin_out <= 1'b1;
            cmd_oe      <= 1'b0;
            done        <= 1'b0;
            resp_valid  <= 1'b0;
            response    <= '0;
            crc_err     <= 1'b0;
            end_bit_err <= 1'b0;
            index_err   <= 1'b0;
            timeout_err <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            index_q     <= '0;
            crc_chk_q   <= 1'b0;
            idx_chk_q   <= 1'b0;
            tmo_en_q    <= 1'b0;
            resp_none_q <= 1'b0;
            resp_long_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (cmd_start) begin
                    tx_shift  <= {2'b01, cmd_index, cmd_argument};
                    rx_shift  <= '0;
                    bit_cnt   <= '0;
                    wait_cnt  <= '0;
                    index_q   <= cmd_index;
                    crc_chk_q <= crc_check_en;
                    idx_chk_q <= index_check_en;
                    tmo_en_q  <= timeout_enable;
                    case (resp_type)
                        RESP_NONE:         begin resp_none_q <= 1'b1; resp_long_q <= 1'b0; end
                        RESP_136:          begin resp_none_q <= 1'b0; resp_long_q <= 1'b1; end
                        RESP_48, RESP_48B: begin resp_none_q <= 1'b0; resp_long_q <= 1'b0; end
                    endcase
                    state <= ST_SEND;
                end
                // Each strobe drives the next frame bit; the strobe after the end bit releases the line.
                ST_SEND: if (bit_en) begin
                    if (bit_cnt == 8'(FRAME_LEN_48)) begin
                        cmd_oe      <= 1'b0;
                        cmd_pin_out <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= resp_none_q ? ST_CHECK : ST_TURN;
                    end else begin
                        cmd_oe  <= 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt < 8'd40) begin
                            cmd_pin_out <= tx_shift[39];
                            tx_shift    <= {tx_shift[38:0], 1'b0};
                        end else if (bit_cnt < 8'd47) begin
                            cmd_pin_out <= crc_tx[3'd6 - bit_cnt[2:0]];
                        end else begin
                            cmd_pin_out <= 1'b1;
                        end
                    end
                end
                ST_TURN: if (bit_en) begin
                    if (bit_cnt == 8'd1) begin
                        bit_cnt  <= '0;
                        wait_cnt <= '0;
                        state    <= ST_WAIT_START;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                // A start bit wins over a timeout landing on the same strobe.
                ST_WAIT_START: if (bit_en) begin
                    if (!cmd_pin_in) begin
                        rx_shift <= {rx_shift[126:0], 1'b0};
                        bit_cnt  <= 8'd1;
                        state    <= ST_RECV;
                    end else if (tmo_en_q && (wait_cnt == TW'(TIMEOUT_BITS - 1))) begin
                        timeout_err <= 1'b1;
                        state       <= ST_CHECK;
                    end else if (wait_cnt != TW'(TIMEOUT_BITS)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RECV: if (bit_en) begin
                    rx_shift <= {rx_shift[126:0], cmd_pin_in};
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (bit_cnt == last_bit) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    done <= 1'b1;
                    if (resp_none_q) begin
`ifdef SDHOST_CMD_NCC_EN
                        cmd_oe      <= 1'b1;
                        cmd_pin_out <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= ST_NCC;
`else
                        state <= ST_IDLE;
`endif
                    end else begin
                        resp_valid <= 1'b1;
                        if (!timeout_err) begin
                            response    <= resp_long_q ? {8'd0, rx_shift[127:8]} : {96'd0, rx_shift[39:8]};
                            index_err   <= !resp_long_q && idx_chk_q && (rx_shift[45:40] != index_q);
                            crc_err     <= crc_chk_q && (crc_rx != rx_shift[7:1]);
                            end_bit_err <= !rx_shift[0];
                        end
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: if (resp_ack) begin
                    resp_valid  <= 1'b0;
                    crc_err     <= 1'b0;
                    end_bit_err <= 1'b0;
                    index_err   <= 1'b0;
                    timeout_err <= 1'b0;
`ifdef SDHOST_CMD_NCC_EN
                    cmd_oe      <= 1'b1;
                    cmd_pin_out <= 1'b1;
                    bit_cnt     <= '0;
                    state       <= ST_NCC;
`else
                    state <= ST_IDLE;
`endif
                end
`ifdef SDHOST_CMD_NCC_EN
                ST_NCC: if (bit_en) begin
                    if (bit_cnt == 8'(NCC_BITS - 1)) begin
                        cmd_oe <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Scoreboard bench for sd_cmd_phy: expected frames/results are queued by the stimulus and popped by monitors.
module tb_sd_cmd_phy;

    typedef struct {
        logic         rv;
        logic         chk_resp;
        logic [127:0] resp;
        logic         crc;
        logic         endb;
        logic         idx;
        logic         tmo;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         bit_en = 1'b0;
    logic         cmd_start = 1'b0;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_argument = '0;
    logic [1:0]   resp_type = '0;
    logic         crc_check_en = 1'b0;
    logic         index_check_en = 1'b0;
    logic         timeout_enable = 1'b0;
    logic         cmd_pin_in = 1'b1;
    logic         resp_ack = 1'b0;
    logic         cmd_pin_out, cmd_oe, busy, done, resp_valid;
    logic [127:0] response;
    logic         crc_err, end_bit_err, index_err, timeout_err;

    int           n_compared = 0;
    int           n_mismatched = 0;
    logic [47:0]  exp_tx[$];
    exp_t         exp_done[$];
    int           div = 0;

    sd_cmd_phy #(.TIMEOUT_BITS(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .bit_en         (bit_en),
        .cmd_start      (cmd_start),
        .cmd_index      (cmd_index),
        .cmd_argument   (cmd_argument),
        .resp_type      (resp_type),
        .crc_check_en   (crc_check_en),
        .index_check_en (index_check_en),
        .timeout_enable (timeout_enable),
        .cmd_pin_in     (cmd_pin_in),
        .cmd_pin_out    (cmd_pin_out),
        .cmd_oe         (cmd_oe),
        .busy           (busy),
        .done           (done),
        .response       (response),
        .resp_valid     (resp_valid),
        .resp_ack       (resp_ack),
        .crc_err        (crc_err),
        .end_bit_err    (end_bit_err),
        .index_err      (index_err),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    // One-clock strobe every fourth clock, changed just after the edge.
    always @(posedge clock) begin
        #1;
        div    = (div == 3) ? 0 : div + 1;
        bit_en = (div == 3);
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic exp_t mk_exp(input logic rv, input logic chk, input logic [127:0] resp,
                                    input logic crc, input logic endb, input logic idx, input logic tmo);
        exp_t e;
        e.rv = rv; e.chk_resp = chk; e.resp = resp;
        e.crc = crc; e.endb = endb; e.idx = idx; e.tmo = tmo;
        return e;
    endfunction

    function automatic logic [6:0] crc7_of(input logic [127:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // TX monitor: collects the bits on the line while the pad is driven.
    logic [47:0] tx_frame = '0;
    int          tx_cnt = 0;
    always @(negedge clock) begin
        if (!reset) begin
            tx_cnt = 0;
        end else if (bit_en && cmd_oe) begin
            tx_frame = {tx_frame[46:0], cmd_pin_out};
            tx_cnt++;
            if (tx_cnt == 48) begin
                tx_cnt = 0;
                if (exp_tx.size() == 0) begin
                    checkOutput("tx_unexpected", {80'd0, tx_frame}, 128'd0);
                end else begin
                    checkOutput("tx_frame", {80'd0, tx_frame}, {80'd0, exp_tx.pop_front()});
                end
            end
        end
    end

    // Completion monitor: done must be a single-clock pulse carrying the queued result.
    logic done_prev = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (reset && done_prev) checkOutput("done_pulse", {127'd0, done}, 128'd0);
        if (reset && done) begin
            if (exp_done.size() == 0) begin
                checkOutput("done_unexpected", {127'd0, done}, 128'd0);
            end else begin
                e = exp_done.pop_front();
                checkOutput("resp_valid", {127'd0, resp_valid}, {127'd0, e.rv});
                if (e.rv) begin
                    checkOutput("flags", {124'd0, crc_err, end_bit_err, index_err, timeout_err},
                                {124'd0, e.crc, e.endb, e.idx, e.tmo});
                    if (e.chk_resp) checkOutput("response", response, e.resp);
                end
            end
        end
        done_prev = done;
    end

    task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rtype,
                                 input logic crc_en, input logic idx_en, input logic tmo_en,
                                 input logic [47:0] tx, input exp_t e, input bit push);
        if (push) begin
            exp_tx.push_back(tx);
            exp_done.push_back(e);
        end
        @(negedge clock);
        cmd_index = idx; cmd_argument = arg; resp_type = rtype;
        crc_check_en = crc_en; index_check_en = idx_en; timeout_enable = tmo_en;
        cmd_start = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
    endtask

    task automatic wait_oe(input logic want);
        int n = 0;
        while (cmd_oe !== want && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checkOutput(want ? "oe_rise" : "oe_fall", {127'd0, cmd_oe}, {127'd0, want});
    endtask

    task automatic wait_strobes(input int n);
        repeat (n) @(posedge clock iff bit_en);
        #1;
    endtask

    task automatic send_reply(input logic [135:0] r, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            cmd_pin_in = r[i];
            wait_strobes(1);
        end
        cmd_pin_in = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_tx.size() + exp_done.size()) != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        checkOutput("drain", 128'(exp_tx.size() + exp_done.size()), 128'd0);
    endtask

    task automatic hold_and_ack();
        repeat (10) @(negedge clock);
        checkOutput("hold_valid", {127'd0, resp_valid}, 128'd1);
        resp_ack = 1'b1;
        @(negedge clock);
        resp_ack = 1'b0;
        checkOutput("ack_clear", {122'd0, resp_valid, busy, crc_err, end_bit_err, index_err, timeout_err}, 128'd0);
    endtask

    task automatic run_resp(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rtype,
                            input logic crc_en, input logic idx_en, input logic tmo_en,
                            input logic [47:0] tx, input logic [135:0] reply, input int len,
                            input int delay, input exp_t e);
        applyStimulus(idx, arg, rtype, crc_en, idx_en, tmo_en, tx, e, 1'b1);
        wait_oe(1'b1);
        wait_oe(1'b0);
        wait_strobes(delay);
        checkOutput("busy_wait", {127'd0, busy}, 128'd1);
        send_reply(reply, len);
        drain();
        hold_and_ack();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [47:0]  tx8;
        logic [39:0]  cmd2_body;
        logic [119:0] cid;
        logic [135:0] r136;
        int           cnt;
        int           n;

        tx8       = 48'h48000001AA87;
        cmd2_body = 40'h4200000000;
        cid       = 120'h0123456789ABCDEF0123456789ABDE;
        r136      = {8'h3F, cid, crc7_of(128'(cid), 120), 1'b1};

        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("reset_state", {121'd0, cmd_pin_out, cmd_oe, busy, done, resp_valid, crc_err | end_bit_err, index_err | timeout_err},
                    {121'd0, 7'b1000000});
        checkOutput("reset_response", response, 128'd0);

        // CMD0, no response
        applyStimulus(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 48'h400000000095, mk_exp(0, 0, 0, 0, 0, 0, 0), 1'b1);
        drain();
        @(negedge clock);
        checkOutput("cmd0_idle", {126'd0, busy, resp_valid}, 128'd0);

        // CMD8 with good, bad end bit, bad CRC (checked and unchecked) and bad index replies
        run_resp(6'd8, 32'h1AA, 2'b10, 1, 1, 1, tx8, 136'h08000001AA13, 48, 5, mk_exp(1, 1, 128'h1AA, 0, 0, 0, 0));
        run_resp(6'd8, 32'h1AA, 2'b10, 1, 1, 1, tx8, 136'h08000001AA12, 48, 5, mk_exp(1, 1, 128'h1AA, 0, 1, 0, 0));
        run_resp(6'd8, 32'h1AA, 2'b10, 1, 1, 1, tx8, 136'h08000001AA15, 48, 5, mk_exp(1, 1, 128'h1AA, 1, 0, 0, 0));
        run_resp(6'd8, 32'h1AA, 2'b11, 0, 1, 1, tx8, 136'h08000001AA15, 48, 5, mk_exp(1, 1, 128'h1AA, 0, 0, 0, 0));
        run_resp(6'd8, 32'h1AA, 2'b10, 0, 1, 1, tx8, 136'h09000001AA13, 48, 5, mk_exp(1, 1, 128'h1AA, 0, 0, 1, 0));

        // Start bit on the very strobe where the timeout would fire
        run_resp(6'd8, 32'h1AA, 2'b10, 1, 1, 1, tx8, 136'h08000001AA13, 48, 65, mk_exp(1, 1, 128'h1AA, 0, 0, 0, 0));

        // No reply with timeout enabled: two turnaround strobes plus 64 wait strobes
        applyStimulus(6'd8, 32'h1AA, 2'b10, 1, 1, 1, tx8, mk_exp(1, 0, 0, 0, 0, 0, 1), 1'b1);
        wait_oe(1'b1);
        wait_oe(1'b0);
        cnt = 0;
        n   = 0;
        while (!timeout_err && n < 1000) begin
            if (bit_en) cnt++;
            @(negedge clock);
            n++;
        end
        checkOutput("timeout_bits", 128'(cnt), 128'd66);
        drain();
        hold_and_ack();

        // No timeout: still waiting after 200 bit periods, then a late reply completes
        run_resp(6'd8, 32'h1AA, 2'b10, 1, 1, 0, tx8, 136'h08000001AA13, 48, 200, mk_exp(1, 1, 128'h1AA, 0, 0, 0, 0));

        // CMD2 with a 136-bit CID reply; index field is not checked
        run_resp(6'd2, 32'h0, 2'b01, 1, 1, 1, {cmd2_body, crc7_of(128'(cmd2_body), 40), 1'b1}, r136, 136, 5,
                 mk_exp(1, 1, {8'd0, cid}, 0, 0, 0, 0));

        // Reset in the middle of SEND, then a clean command
        applyStimulus(6'd8, 32'h1AA, 2'b10, 1, 1, 1, tx8, mk_exp(0, 0, 0, 0, 0, 0, 0), 1'b0);
        wait_oe(1'b1);
        wait_strobes(20);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("reset_abort", {125'd0, cmd_oe, cmd_pin_out, busy}, {125'd0, 3'b010});
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 48'h400000000095, mk_exp(0, 0, 0, 0, 0, 0, 0), 1'b1);
        drain();

        repeat (5) @(negedge clock);
        checkOutput("queues_empty", 128'(exp_tx.size() + exp_done.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
